// File: rtl/sha256_digest_serializer.sv
// -----------------------------------------------------------------------------
// sha256_digest_serializer
//
// Captures a 256-bit SHA-256 digest on the core's one-cycle hash_valid pulse
// and streams it out MSB first over a valid/ready byte interface. The stream
// is either 32 raw bytes or 64 ASCII hex characters.
//
// Handshake: a beat transfers on any rising clk edge where
// out_valid && out_ready. Once out_valid is high it stays high, and
// out_data/out_last hold steady, until the beat transfers.
//
// Ports:
//   clk           clock
//   rst_n         asynchronous active-low reset
//   hash_in       digest from the core, sampled when hash_valid=1
//   hash_valid    one-cycle pulse qualifying hash_in
//   out_data      current output byte / character (registered)
//   out_valid     out_data is valid
//   out_ready     sink accepts out_data this cycle
//   out_last      final beat of the digest (qualified by out_valid)
//   busy          a digest is held or being sent; mirrors state SEND
//   overrun       sticky flag: a digest arrived mid-stream and was dropped
//   clear_overrun synchronous clear of overrun (a same-cycle drop wins)
// -----------------------------------------------------------------------------
module sha256_digest_serializer #(
    parameter bit HEX_ASCII = 1'b0,
    parameter bit UPPERCASE = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] hash_in,
    input  logic         hash_valid,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy,
    output logic         overrun,
    input  logic         clear_overrun
);

    // Bits consumed per beat and index of the final beat.
    localparam int         STEP      = HEX_ASCII ? 4 : 8;
    localparam logic [5:0] LAST_BEAT = HEX_ASCII ? 6'd63 : 6'd31;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [255:0]   shift_q, shift_d;
    logic [5:0]     cnt_q, cnt_d;
    logic [7:0]     data_q, data_d;
    logic           overrun_q, overrun_d;

    logic           xfer;
    logic           last_xfer;
    logic           accept;
    logic           drop;

    // The beat to present always sits in the top bits of the shift register,
    // so encoding only ever looks at the top byte / nibble.
    function automatic logic [7:0] encode(input logic [255:0] sr);
        logic [3:0] nib;
        nib = sr[255:252];
        if (!HEX_ASCII) begin
            encode = sr[255:248];
        end else if (nib < 4'd10) begin
            encode = 8'h30 + {4'h0, nib};
        end else if (UPPERCASE) begin
            encode = 8'h37 + {4'h0, nib};   // 'A' - 10
        end else begin
            encode = 8'h57 + {4'h0, nib};   // 'a' - 10
        end
    endfunction

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        overrun_d = overrun_q;

        xfer      = (state_q == SEND) && out_ready;
        last_xfer = xfer && (cnt_q == LAST_BEAT);
        // A digest landing on the last-beat transfer chains straight into a
        // new stream with no bubble; anywhere else in SEND it is dropped.
        accept    = hash_valid && ((state_q == IDLE) || last_xfer);
        drop      = hash_valid && (state_q == SEND) && !last_xfer;

        if (accept) begin
            state_d = SEND;
            shift_d = hash_in;
            cnt_d   = 6'd0;
            data_d  = encode(hash_in);
        end else if (last_xfer) begin
            state_d = IDLE;
        end else if (xfer) begin
            shift_d = shift_q << STEP;
            cnt_d   = cnt_q + 6'd1;
            data_d  = encode(shift_q << STEP);
        end

        if (drop) begin
            overrun_d = 1'b1;
        end else if (clear_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = (state_q == SEND);
    assign out_last  = (state_q == SEND) && (cnt_q == LAST_BEAT);
    assign busy      = (state_q == SEND);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sha256_digest_serializer.sv
// -----------------------------------------------------------------------------
// tb_sha256_digest_serializer
//
// Three instances share clock, reset, hash_in, out_ready and clear_overrun:
//   [0] raw bytes, [1] hex lowercase, [2] hex uppercase.
// Tests run one instance at a time; 'sel' names the active one. Expected
// beats ({last, data}) are pushed to exp_q when a digest is driven and popped
// by the monitor on every transfer of the active instance.
// -----------------------------------------------------------------------------
module tb_sha256_digest_serializer;

    localparam logic [255:0] ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_B = 256'h1;
    localparam logic [255:0] DIG_C =
        256'h0123456789abcdeffedcba98765432100f1e2d3c4b5a69788796a5b4c3d2e1f0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [255:0] hash_in;
    logic [2:0]   hv;
    logic [7:0]   od [3];
    logic [2:0]   ov, ol, bz, orn;
    logic         out_ready;
    logic         clear_overrun;

    sha256_digest_serializer #(.HEX_ASCII(1'b0), .UPPERCASE(1'b0)) dut_raw (
        .clk(clk), .rst_n(rst_n), .hash_in(hash_in), .hash_valid(hv[0]),
        .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
        .out_last(ol[0]), .busy(bz[0]), .overrun(orn[0]),
        .clear_overrun(clear_overrun));

    sha256_digest_serializer #(.HEX_ASCII(1'b1), .UPPERCASE(1'b0)) dut_hexl (
        .clk(clk), .rst_n(rst_n), .hash_in(hash_in), .hash_valid(hv[1]),
        .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
        .out_last(ol[1]), .busy(bz[1]), .overrun(orn[1]),
        .clear_overrun(clear_overrun));

    sha256_digest_serializer #(.HEX_ASCII(1'b1), .UPPERCASE(1'b1)) dut_hexu (
        .clk(clk), .rst_n(rst_n), .hash_in(hash_in), .hash_valid(hv[2]),
        .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready),
        .out_last(ol[2]), .busy(bz[2]), .overrun(orn[2]),
        .clear_overrun(clear_overrun));

    // ---------------- scoreboard state ----------------
    logic [8:0] exp_q[$];
    int         sel      = 0;
    int         xfer_cnt = 0;
    int         n_checks = 0;
    int         n_fail   = 0;
    bit         rand_bp  = 1'b0;

    string hexl = "0123456789abcdef";
    string hexu = "0123456789ABCDEF";

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected beats for the active instance.
    task automatic push_digest(input logic [255:0] h);
        logic [7:0] c;
        logic [3:0] n;
        if (sel == 0) begin
            for (int k = 0; k < 32; k++) begin
                c = h[255 - 8*k -: 8];
                exp_q.push_back({(k == 31), c});
            end
        end else begin
            for (int k = 0; k < 64; k++) begin
                n = h[255 - 4*k -: 4];
                c = (sel == 2) ? hexu[n] : hexl[n];
                exp_q.push_back({(k == 63), c});
            end
        end
    endtask

    // ---------------- monitor ----------------
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [8:0] e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid", 64'(ov[sel]), 64'd1);
                check_eq("stall_data", 64'(od[sel]), 64'(prev_data));
                check_eq("stall_last", 64'(ol[sel]), 64'(prev_last));
            end
            if (ov[sel] && out_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_beat", 64'(od[sel]), 64'h1ff);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("beat_data", 64'(od[sel]), 64'(e[7:0]));
                    check_eq("beat_last", 64'(ol[sel]), 64'(e[8]));
                end
            end
            prev_stall = ov[sel] && !out_ready;
            prev_data  = od[sel];
            prev_last  = ol[sel];
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse(input int idx, input logic [255:0] h);
        @(posedge clk); #1;
        hash_in = h;
        hv[idx] = 1'b1;
        @(posedge clk); #1;
        hv[idx] = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bz[sel]) && n < budget) begin
            @(posedge clk); #1;
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        check_eq("done_in_time", 64'(n < budget), 64'd1);
    endtask

    task automatic wait_xfers(input int target, input int budget);
        int n;
        n = 0;
        while (xfer_cnt < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("reach_beat", 64'(xfer_cnt >= target), 64'd1);
    endtask

    task automatic run_stream(input int idx, input logic [255:0] h, input int beats);
        int base;
        sel  = idx;
        base = xfer_cnt;
        push_digest(h);
        pulse(idx, h);
        wait_done(400);
        check_eq("stream_count", 64'(xfer_cnt - base), 64'(beats));
        check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    int base;
    int n;

    initial begin
        rst_n         = 1'b0;
        hash_in       = '0;
        hv            = '0;
        out_ready     = 1'b1;
        clear_overrun = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_eq("rst_valid", 64'(ov[i]), 64'd0);
            check_eq("rst_data", 64'(od[i]), 64'd0);
            check_eq("rst_last", 64'(ol[i]), 64'd0);
            check_eq("rst_busy", 64'(bz[i]), 64'd0);
            check_eq("rst_overrun", 64'(orn[i]), 64'd0);
        end
        rst_n = 1'b1;

        // Raw stream: latency and full-rate throughput.
        sel  = 0;
        base = xfer_cnt;
        push_digest(ABC);
        @(posedge clk); #1;
        hash_in = ABC;
        hv[0]   = 1'b1;
        check_eq("idle_before_pulse", 64'(ov[0]), 64'd0);
        @(posedge clk); #1;
        hv[0] = 1'b0;
        check_eq("first_valid", 64'(ov[0]), 64'd1);
        repeat (31) @(posedge clk);
        #1;
        check_eq("busy_on_last", 64'(bz[0]), 64'd1);
        @(posedge clk); #1;
        check_eq("busy_drop", 64'(bz[0]), 64'd0);
        check_eq("valid_drop", 64'(ov[0]), 64'd0);
        check_eq("raw_count", 64'(xfer_cnt - base), 64'd32);
        check_eq("raw_queue_empty", 64'(exp_q.size()), 64'd0);

        // Hex streams, lowercase and uppercase.
        run_stream(1, ABC, 64);
        run_stream(2, ABC, 64);
        run_stream(2, DIG_C, 64);

        // Random backpressure on the raw stream.
        rand_bp = 1'b1;
        run_stream(0, ABC, 32);
        run_stream(0, DIG_C, 32);
        rand_bp   = 1'b0;
        out_ready = 1'b1;

        // Overrun: second digest at beat 10 is dropped.
        sel  = 0;
        base = xfer_cnt;
        push_digest(ABC);
        pulse(0, ABC);
        wait_xfers(base + 10, 100);
        hash_in = DIG_C;
        hv[0]   = 1'b1;
        @(posedge clk); #1;
        hv[0] = 1'b0;
        check_eq("overrun_set", 64'(orn[0]), 64'd1);
        wait_done(200);
        check_eq("overrun_stream_count", 64'(xfer_cnt - base), 64'd32);
        check_eq("overrun_sticky", 64'(orn[0]), 64'd1);
        clear_overrun = 1'b1;
        @(posedge clk); #1;
        clear_overrun = 1'b0;
        check_eq("overrun_clear", 64'(orn[0]), 64'd0);

        // Drop and clear in the same cycle: set wins.
        base = xfer_cnt;
        push_digest(DIG_C);
        pulse(0, DIG_C);
        hash_in       = ABC;
        hv[0]         = 1'b1;
        clear_overrun = 1'b1;
        @(posedge clk); #1;
        hv[0]         = 1'b0;
        clear_overrun = 1'b0;
        check_eq("overrun_set_wins", 64'(orn[0]), 64'd1);
        wait_done(200);
        check_eq("setwins_stream_count", 64'(xfer_cnt - base), 64'd32);
        clear_overrun = 1'b1;
        @(posedge clk); #1;
        clear_overrun = 1'b0;
        check_eq("overrun_clear2", 64'(orn[0]), 64'd0);

        // Digest coincident with last-beat transfer chains without a bubble.
        base = xfer_cnt;
        push_digest(ABC);
        push_digest(DIG_B);
        pulse(0, ABC);
        n = 0;
        while (!ol[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("saw_last", 64'(ol[0]), 64'd1);
        hash_in = DIG_B;
        hv[0]   = 1'b1;
        @(posedge clk); #1;
        hv[0] = 1'b0;
        check_eq("no_bubble", 64'(ov[0]), 64'd1);
        check_eq("chain_no_overrun", 64'(orn[0]), 64'd0);
        wait_done(200);
        check_eq("chain_count", 64'(xfer_cnt - base), 64'd64);
        check_eq("chain_queue_empty", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset at beat 5.
        base = xfer_cnt;
        push_digest(ABC);
        pulse(0, ABC);
        wait_xfers(base + 5, 100);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 64'(ov[0]), 64'd0);
        check_eq("arst_data", 64'(od[0]), 64'd0);
        check_eq("arst_last", 64'(ol[0]), 64'd0);
        check_eq("arst_busy", 64'(bz[0]), 64'd0);
        check_eq("arst_overrun", 64'(orn[0]), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("post_rst_idle", 64'(ov[0]), 64'd0);
        run_stream(0, ABC, 32);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sha256_digest_serializer.md
Name: sha256_digest_serializer

Overview:
- Downstream stage of the SHA-256 core. Captures the 256-bit digest on the core's one-cycle hash_valid pulse.
- Streams the digest out as bytes over a valid/ready interface, for a UART/FIFO sink.
- Output is raw binary (32 beats) or lowercase/uppercase ASCII hex (64 beats).
- Detects and flags digests that arrive while a previous digest is still being sent.

Parameters:
- HEX_ASCII, 0, 0 = raw bytes (32 beats); 1 = ASCII hex characters (64 beats)
- UPPERCASE, 0, applies only when HEX_ASCII=1; 1 selects 'A'-'F', 0 selects 'a'-'f'

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- hash_in  input  256  digest from the SHA-256 core; sampled only when hash_valid=1
- hash_valid  input  1  one-cycle pulse: hash_in is valid
- out_data  output  8  current output byte/character
- out_valid  output  1  out_data is valid
- out_ready  input  1  sink accepts out_data this cycle
- out_last  output  1  high with out_valid on the final beat of a digest
- busy  output  1  high while a digest is held or being sent (state SEND)
- overrun  output  1  sticky: a digest was dropped
- clear_overrun  input  1  synchronous clear of overrun

Behaviour:
- Reset (async, rst_n=0): state IDLE; out_data=0x00, out_valid=0, out_last=0, busy=0, overrun=0; shift register and beat counter = 0.
- Beat count N = 32 (HEX_ASCII=0) or 64 (HEX_ASCII=1). Beat counter is 6 bits and counts 0..N-1 with no wrap past N-1.
- State IDLE:
  - hash_valid=1: latch hash_in into the 256-bit holding register, counter=0, go to SEND.
  - out_valid rises the next cycle, giving 1 cycle from hash_valid to first out_valid.
- State SEND:
  - out_valid=1 and busy=1.
  - A transfer occurs when out_valid && out_ready.
  - On each transfer the counter increments and the next beat is presented the following cycle, so throughput is 1 beat/cycle with out_ready held high.
- Byte order is MSB first.
  - Raw mode: beat k = hash[255-8k -: 8].
  - Hex mode: beat k = nibble hash[255-4k -: 4], high nibble first.
  - Nibble encoding: 0-9 -> 0x30-0x39; 10-15 -> 0x61-0x66 (UPPERCASE=0) or 0x41-0x46 (UPPERCASE=1).
- out_last=1 exactly when counter = N-1 and out_valid=1.
- A transfer with out_last=1 returns the block to IDLE. Next cycle: out_valid=0, out_last=0, busy=0.
- Stall: while out_valid && !out_ready, out_data, out_last and the counter hold stable. The valid/ready protocol permits no retraction.
- hash_valid while in SEND (except the last-beat case below): the new digest is dropped and overrun is set to 1 on the next cycle. The digest in progress continues unaffected.
- hash_valid in the same cycle as the last-beat transfer: the new digest is accepted, not counted as overrun.
  - It is latched, the counter is set to 0, and the block stays in SEND.
  - out_valid stays high with beat 0 of the new digest next cycle; no bubble.
- overrun is sticky until clear_overrun=1, which clears it next cycle.
  - If clear_overrun and a new drop occur in the same cycle, set wins and overrun=1.
- out_data is registered. It holds its last value in IDLE and is don't-care while out_valid=0.
- Reset mid-stream: the stream aborts immediately and no out_last is issued. After release the block sits in IDLE awaiting hash_valid.

Test Plan:
- HEX_ASCII=0, out_ready=1, hash_in = SHA-256("abc") = ba7816bf...f20015ad, pulse hash_valid -> 32 beats on consecutive cycles starting 1 cycle later. Beats: 0xBA, 0x78, 0x16, 0xBF, ..., 0x15, 0xAD. out_last only on 0xAD; busy drops the cycle after.
- HEX_ASCII=1, UPPERCASE=0, same digest -> 64 beats. First 0x62 'b', 0x61 'a', 0x37 '7', 0x38 '8'; last 0x61 'a', 0x64 'd' with out_last. Repeat with UPPERCASE=1 -> first beat 0x42 'B'.
- Random out_ready backpressure (about 50% duty) -> out_data/out_last stable during every stall and the byte sequence is identical to the test above. Total transfers = 32.
- Second hash_valid pulse at beat 10 of a raw stream -> overrun=1 the next cycle and the stream completes with the first digest. clear_overrun pulse -> overrun=0. Pulse clear_overrun together with another drop -> overrun remains 1.
- hash_valid coincident with the last-beat transfer (digest B = 0x00..01) -> no overrun, no out_valid bubble. Next 32 beats are 0x00 x31 then 0x01 with out_last.
- Assert rst_n=0 asynchronously at beat 5 -> all outputs 0 immediately. After release, out_valid stays 0 until the next hash_valid, then a full 32-beat stream follows.
